// File: rtl/k423_pkg.sv
// Shared types and constants for the k423 load/store unit.
package k423_pkg;

  // Byte strobe width for the 32-bit data path
  localparam int STRB_W = 4;

  // Access size encodings presented by EX
  localparam int            SIZE_W    = 2;
  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } lsu_state_e;

endpackage

// File: rtl/k423_lsu_align.sv
// Byte strobe, lane replication and misalignment detection for one access.
module k423_lsu_align
  import k423_pkg::*;
(
  input  logic              store,
  input  logic [SIZE_W-1:0] size,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       lane_data,
  output logic [STRB_W-1:0] wstrb,
  output logic [31:0]       wdata,
  output logic              misalign
);

  // Decode size into strobes/replicated data; loads carry no strobes or data
  always_comb begin
    wstrb    = 4'b1111;
    wdata    = lane_data;
    misalign = 1'b0;
    case (size)
      SIZE_BYTE: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{lane_data[7:0]}};
      end
      SIZE_HALF: begin
        wstrb    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata    = {2{lane_data[15:0]}};
        misalign = addr_lo[0];
      end
      default: begin
        misalign = |addr_lo;
      end
    endcase
    if (!store) begin
      wstrb = '0;
      wdata = '0;
    end
  end

endmodule

// File: rtl/k423_lsu.sv
// Load/store request unit: one outstanding memory request, response buffer to MEM.
module k423_lsu
  import k423_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              lsu_vld_i,
  output logic              lsu_rdy_o,
  input  logic              lsu_store_i,
  input  logic [SIZE_W-1:0] lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic              mem_data_req_vld_o,
  input  logic              mem_data_req_rdy_i,
  output logic              mem_data_req_we_o,
  output logic [ADDR_W-1:0] mem_data_req_addr_o,
  output logic [STRB_W-1:0] mem_data_req_wstrb_o,
  output logic [XLEN-1:0]   mem_data_req_wdata_o,
  input  logic              mem_data_rsp_vld_i,
  input  logic [XLEN-1:0]   mem_data_rsp_rdata_i,
  output logic              lsu_out_vld_o,
  input  logic              lsu_out_rdy_i,
  output logic [XLEN-1:0]   lsu_out_rdata_o,
  output logic              lsu_out_err_o
);

  lsu_state_e        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic [STRB_W-1:0] al_wstrb;
  logic [XLEN-1:0]   al_wdata;
  logic              al_misalign;
  logic              accept;
  logic              capture;

  k423_lsu_align u_align (
    .store     (lsu_store_i),
    .size      (lsu_size_i),
    .addr_lo   (lsu_addr_i[1:0]),
    .lane_data (lsu_wdata_i),
    .wstrb     (al_wstrb),
    .wdata     (al_wdata),
    .misalign  (al_misalign)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and accept/capture; flush overrides every other event
  always_comb begin
    state_nxt = state;
    lsu_rdy_o = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        lsu_rdy_o = ~flush_i;
        if (lsu_vld_i && !flush_i) state_nxt = al_misalign ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (flush_i)                 state_nxt = mem_data_req_rdy_i ? ST_DRAIN : ST_IDLE;
        else if (mem_data_req_rdy_i) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_data_rsp_vld_i) begin
          state_nxt = flush_i ? ST_IDLE : ST_DONE;
          capture   = ~flush_i;
        end else if (flush_i) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (flush_i) begin
          state_nxt = ST_IDLE;
        end else if (lsu_out_rdy_i) begin
          // Back-to-back: the slot frees this cycle, so take the next op now
          lsu_rdy_o = 1'b1;
          if (lsu_vld_i) state_nxt = al_misalign ? ST_DONE : ST_REQ;
          else           state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mem_data_rsp_vld_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept = lsu_vld_i & lsu_rdy_o;

  // Op registers (stable while the request waits) and response buffer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
      we_q    <= lsu_store_i;
      wstrb_q <= al_wstrb;
      wdata_q <= al_wdata;
      rdata_q <= '0;
      err_q   <= al_misalign;
    end else if (capture) begin
      rdata_q <= mem_data_rsp_rdata_i;
    end
  end

  assign mem_data_req_vld_o   = (state == ST_REQ);
  assign mem_data_req_we_o    = we_q;
  assign mem_data_req_addr_o  = addr_q;
  assign mem_data_req_wstrb_o = wstrb_q;
  assign mem_data_req_wdata_o = wdata_q;
  assign lsu_out_vld_o        = (state == ST_DONE);
  assign lsu_out_rdata_o      = rdata_q;
  assign lsu_out_err_o        = err_q;

endmodule

// File: tb/tb_k423_lsu.sv
// Scenario bench for k423_lsu with an expected-result queue for MEM-side outputs.
module tb_k423_lsu;
  import k423_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        lsu_vld = 1'b0;
  logic        lsu_rdy;
  logic        lsu_store = 1'b0;
  logic [1:0]  lsu_size = SIZE_WORD;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        req_vld;
  logic        req_rdy = 1'b1;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        rsp_vld = 1'b0;
  logic [31:0] rsp_rdata = '0;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic [31:0] out_rdata;
  logic        out_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  k423_lsu #(.ADDR_W(32), .XLEN(32)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .flush_i              (flush),
    .lsu_vld_i            (lsu_vld),
    .lsu_rdy_o            (lsu_rdy),
    .lsu_store_i          (lsu_store),
    .lsu_size_i           (lsu_size),
    .lsu_addr_i           (lsu_addr),
    .lsu_wdata_i          (lsu_wdata),
    .mem_data_req_vld_o   (req_vld),
    .mem_data_req_rdy_i   (req_rdy),
    .mem_data_req_we_o    (req_we),
    .mem_data_req_addr_o  (req_addr),
    .mem_data_req_wstrb_o (req_wstrb),
    .mem_data_req_wdata_o (req_wdata),
    .mem_data_rsp_vld_i   (rsp_vld),
    .mem_data_rsp_rdata_i (rsp_rdata),
    .lsu_out_vld_o        (out_vld),
    .lsu_out_rdy_i        (out_rdy),
    .lsu_out_rdata_o      (out_rdata),
    .lsu_out_err_o        (out_err)
  );

  // Inputs change 1 time unit after the rising edge; checks happen 3 units later
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic st, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    lsu_vld   = 1'b1;
    lsu_store = st;
    lsu_size  = sz;
    lsu_addr  = a;
    lsu_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) nxt();
    #3;
    vectors++;
    if ({req_vld, req_we, out_vld, out_err, req_wstrb, req_addr, req_wdata, out_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got vld=%b we=%b ovld=%b err=%b strb=%h addr=%h wd=%h rd=%h want all 0",
               req_vld, req_we, out_vld, out_err, req_wstrb, req_addr, req_wdata, out_rdata);
    end
    vectors++;
    if (lsu_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_rdy got %b want 1", lsu_rdy); end
    nxt();
    rst = 1'b0;
    nxt();
  endtask

  task automatic test_load_word();
    req_rdy = 1'b1;
    offer(1'b0, SIZE_WORD, 32'h100, 32'h0);
    sb.push_back(exp_t'({32'hDEADBEEF, 1'b0}));
    #3;
    vectors++;
    if (lsu_rdy !== 1'b1) begin miscompares++; $display("FAIL ld_accept got %b want 1", lsu_rdy); end
    nxt();
    lsu_vld = 1'b0;
    #3;
    vectors++;
    if ({req_vld, req_we, req_addr, req_wstrb} !== {1'b1, 1'b0, 32'h100, 4'h0}) begin
      miscompares++;
      $display("FAIL ld_req got vld=%b we=%b addr=%h strb=%h want 1 0 00000100 0", req_vld, req_we, req_addr, req_wstrb);
    end
    nxt();
    rsp_vld = 1'b1;
    rsp_rdata = 32'hDEADBEEF;
    #3;
    vectors++;
    if ({req_vld, out_vld} !== 2'b00) begin miscompares++; $display("FAIL ld_wait got req=%b out=%b want 0 0", req_vld, out_vld); end
    nxt();
    rsp_vld = 1'b0;
    #3;
    vectors++;
    if (out_vld !== 1'b1) begin
      miscompares++; $display("FAIL ld_latency got out_vld=%b want 1", out_vld);
    end else if (sb.size() == 0) begin
      miscompares++; $display("FAIL ld_sb_empty got out_vld=1 want no output");
    end else begin
      e = sb.pop_front();
      if ({out_rdata, out_err} !== {e.rdata, e.err}) begin
        miscompares++; $display("FAIL ld_rdata got %h/%b want %h/%b", out_rdata, out_err, e.rdata, e.err);
      end
    end
    nxt();
    #3;
    vectors++;
    if (out_vld !== 1'b0) begin miscompares++; $display("FAIL ld_release got %b want 0", out_vld); end
    nxt();
  endtask

  task automatic test_store();
    logic [1:0]  sz [4] = '{SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_BYTE};
    logic [31:0] a  [4] = '{32'h203, 32'h202, 32'h20C, 32'h201};
    logic [31:0] wd [4] = '{32'hFFFF_FFA5, 32'hABCD_1234, 32'hCAFE_BABE, 32'h0000_003C};
    logic [3:0]  es [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0010};
    logic [31:0] ew [4] = '{32'hA5A5_A5A5, 32'h1234_1234, 32'hCAFE_BABE, 32'h3C3C_3C3C};
    req_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, sz[i], a[i], wd[i]);
      sb.push_back(exp_t'({32'h1111_0000 + i, 1'b0}));
      nxt();
      lsu_vld = 1'b0;
      #3;
      vectors++;
      if ({req_vld, req_we, req_addr, req_wstrb, req_wdata} !== {1'b1, 1'b1, a[i] & 32'hFFFF_FFFC, es[i], ew[i]}) begin
        miscompares++;
        $display("FAIL st_req[%0d] got vld=%b we=%b addr=%h strb=%b wd=%h want 1 1 %h %b %h",
                 i, req_vld, req_we, req_addr, req_wstrb, req_wdata, a[i] & 32'hFFFF_FFFC, es[i], ew[i]);
      end
      nxt();
      rsp_vld = 1'b1;
      rsp_rdata = 32'h1111_0000 + i;
      nxt();
      rsp_vld = 1'b0;
      #3;
      vectors++;
      if (out_vld !== 1'b1 || sb.size() == 0) begin
        miscompares++; $display("FAIL st_done[%0d] got out_vld=%b queued=%0d want 1", i, out_vld, sb.size());
      end else begin
        e = sb.pop_front();
        if ({out_rdata, out_err} !== {e.rdata, e.err}) begin
          miscompares++; $display("FAIL st_rsp[%0d] got %h/%b want %h/%b", i, out_rdata, out_err, e.rdata, e.err);
        end
      end
      nxt();
    end
  endtask

  task automatic test_back_to_back();
    req_rdy = 1'b0;
    offer(1'b0, SIZE_WORD, 32'h300, 32'h0);
    sb.push_back(exp_t'({32'hCAFE_F00D, 1'b0}));
    nxt();
    lsu_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      vectors++;
      if ({req_vld, req_addr, lsu_rdy} !== {1'b1, 32'h300, 1'b0}) begin
        miscompares++; $display("FAIL stall_req[%0d] got vld=%b addr=%h rdy=%b want 1 00000300 0", i, req_vld, req_addr, lsu_rdy);
      end
      nxt();
    end
    req_rdy = 1'b1;
    nxt();
    rsp_vld = 1'b1;
    rsp_rdata = 32'hCAFE_F00D;
    out_rdy = 1'b0;
    nxt();
    rsp_vld = 1'b0;
    rsp_rdata = 32'h0;
    offer(1'b0, SIZE_WORD, 32'h400, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #3;
      vectors++;
      if ({out_vld, out_rdata, lsu_rdy} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
        miscompares++; $display("FAIL hold_out[%0d] got vld=%b rd=%h rdy=%b want 1 cafef00d 0", i, out_vld, out_rdata, lsu_rdy);
      end
      nxt();
    end
    out_rdy = 1'b1;
    #3;
    vectors++;
    if (lsu_rdy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got %b want 1", lsu_rdy); end
    vectors++;
    if (out_vld !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL b2b_out got out_vld=%b queued=%0d want 1", out_vld, sb.size());
    end else begin
      e = sb.pop_front();
      if ({out_rdata, out_err} !== {e.rdata, e.err}) begin
        miscompares++; $display("FAIL b2b_rdata got %h/%b want %h/%b", out_rdata, out_err, e.rdata, e.err);
      end
    end
    sb.push_back(exp_t'({32'h0BAD_CAFE, 1'b0}));
    nxt();
    lsu_vld = 1'b0;
    #3;
    vectors++;
    if ({req_vld, req_addr, out_vld} !== {1'b1, 32'h400, 1'b0}) begin
      miscompares++; $display("FAIL b2b_req got vld=%b addr=%h out=%b want 1 00000400 0", req_vld, req_addr, out_vld);
    end
    nxt();
    rsp_vld = 1'b1;
    rsp_rdata = 32'h0BAD_CAFE;
    nxt();
    rsp_vld = 1'b0;
    #3;
    vectors++;
    if (out_vld !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL b2b_second got out_vld=%b queued=%0d want 1", out_vld, sb.size());
    end else begin
      e = sb.pop_front();
      if ({out_rdata, out_err} !== {e.rdata, e.err}) begin
        miscompares++; $display("FAIL b2b_second_rdata got %h/%b want %h/%b", out_rdata, out_err, e.rdata, e.err);
      end
    end
    nxt();
  endtask

  task automatic test_misalign();
    logic        st [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [3] = '{SIZE_WORD, SIZE_HALF, SIZE_HALF};
    logic [31:0] a  [3] = '{32'h102, 32'h203, 32'h301};
    req_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(st[i], sz[i], a[i], 32'h5555_5555);
      sb.push_back(exp_t'({32'h0, 1'b1}));
      nxt();
      lsu_vld = 1'b0;
      #3;
      vectors++;
      if (req_vld !== 1'b0) begin miscompares++; $display("FAIL mis_noreq[%0d] got %b want 0", i, req_vld); end
      vectors++;
      if (out_vld !== 1'b1 || sb.size() == 0) begin
        miscompares++; $display("FAIL mis_out[%0d] got out_vld=%b queued=%0d want 1", i, out_vld, sb.size());
      end else begin
        e = sb.pop_front();
        if ({out_rdata, out_err} !== {e.rdata, e.err}) begin
          miscompares++; $display("FAIL mis_err[%0d] got %h/%b want %h/%b", i, out_rdata, out_err, e.rdata, e.err);
        end
      end
      nxt();
      #3;
      vectors++;
      if ({req_vld, out_vld} !== 2'b00) begin miscompares++; $display("FAIL mis_after[%0d] got req=%b out=%b want 0 0", i, req_vld, out_vld); end
    end
  endtask

  task automatic test_flush_wait();
    req_rdy = 1'b1;
    offer(1'b0, SIZE_WORD, 32'h500, 32'h0);
    nxt();
    lsu_vld = 1'b0;
    nxt();
    flush = 1'b1;
    nxt();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rsp_vld = (i == 2);
      rsp_rdata = 32'h7777_7777;
      #3;
      vectors++;
      if ({lsu_rdy, out_vld, req_vld} !== 3'b000) begin
        miscompares++; $display("FAIL drain[%0d] got rdy=%b out=%b req=%b want 0 0 0", i, lsu_rdy, out_vld, req_vld);
      end
      nxt();
    end
    rsp_vld = 1'b0;
    #3;
    vectors++;
    if ({lsu_rdy, out_vld} !== 2'b10) begin miscompares++; $display("FAIL drain_done got rdy=%b out=%b want 1 0", lsu_rdy, out_vld); end
    nxt();
    #3;
    vectors++;
    if (out_vld !== 1'b0) begin miscompares++; $display("FAIL drain_no_out got %b want 0", out_vld); end
    nxt();
  endtask

  task automatic test_flush_req();
    req_rdy = 1'b0;
    offer(1'b0, SIZE_WORD, 32'h600, 32'h0);
    nxt();
    lsu_vld = 1'b0;
    flush = 1'b1;
    #3;
    vectors++;
    if (req_vld !== 1'b1) begin miscompares++; $display("FAIL freq_before got %b want 1", req_vld); end
    nxt();
    flush = 1'b0;
    #3;
    vectors++;
    if ({req_vld, lsu_rdy, out_vld} !== 3'b010) begin
      miscompares++; $display("FAIL freq_after got req=%b rdy=%b out=%b want 0 1 0", req_vld, lsu_rdy, out_vld);
    end
    req_rdy = 1'b1;
    nxt();
  endtask

  task automatic test_async_reset();
    req_rdy = 1'b1;
    offer(1'b1, SIZE_BYTE, 32'h701, 32'h0000_00EE);
    nxt();
    lsu_vld = 1'b0;
    nxt();
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({req_vld, req_we, out_vld, out_err, req_wstrb, req_addr, req_wdata, out_rdata} !== '0) begin
      miscompares++;
      $display("FAIL arst_outputs got vld=%b we=%b ovld=%b err=%b strb=%h addr=%h wd=%h rd=%h want all 0",
               req_vld, req_we, out_vld, out_err, req_wstrb, req_addr, req_wdata, out_rdata);
    end
    vectors++;
    if (lsu_rdy !== 1'b1) begin miscompares++; $display("FAIL arst_rdy got %b want 1", lsu_rdy); end
    nxt();
    rst = 1'b0;
    nxt();
    rsp_vld = 1'b1;
    rsp_rdata = 32'h9999_9999;
    nxt();
    rsp_vld = 1'b0;
    #3;
    vectors++;
    if ({out_vld, lsu_rdy, out_rdata} !== {1'b0, 1'b1, 32'h0}) begin
      miscompares++; $display("FAIL late_rsp got out=%b rdy=%b rd=%h want 0 1 00000000", out_vld, lsu_rdy, out_rdata);
    end
    nxt();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store();
    test_back_to_back();
    test_misalign();
    test_flush_wait();
    test_flush_req();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
